// File: rtl/cell_draw_pkg.sv
// Shared constants and state encoding for the Game-of-Life cell drawing controller.
package cell_draw_pkg;

   localparam int GRID_COLS  = 40;
   localparam int GRID_ROWS  = 30;
   localparam int DRAW_BEATS = 17;
   localparam int CELL_PIX   = 4;

   localparam int ROW_W  = 5;
   localparam int COL_W  = 6;
   localparam int BEAT_W = 5;
   localparam int DATA_W = 40;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      DRAW  = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/cell_draw_control_beat_counter.sv
// Beat counter for the DRAW phase; mirrors the datapath's 17-state pixel counter.
module beat_counter
   import cell_draw_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   output logic [BEAT_W-1:0] beat,
   output logic              last
);

   logic [BEAT_W-1:0] beat_q;
   logic [BEAT_W-1:0] beat_d;

   always_comb begin
      last   = (beat_q == BEAT_W'(DRAW_BEATS - 1));
      beat_d = beat_q;
      if (clr) begin
         beat_d = {BEAT_W{1'b0}};
      end else if (en) begin
         beat_d = last ? {BEAT_W{1'b0}} : beat_q + BEAT_W'(1);
      end else begin
         beat_d = beat_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_q <= {BEAT_W{1'b0}};
      end else begin
         beat_q <= beat_d;
      end
   end

   assign beat = beat_q;

endmodule

// File: rtl/cell_draw_control.sv
// Frame-walking initiator: per cell it loads the datapath, then runs 17 enable
// beats of which beats 1..16 carry a valid pixel to the VGA adapter.
module cell_draw_control
   import cell_draw_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] row_data,
   output logic [ROW_W-1:0]  row_addr,
   output logic [COL_W-1:0]  col_addr,
   output logic              ld_x,
   output logic              ld_y,
   output logic              ld_c,
   output logic              enable,
   output logic              plot,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] row_data_out
);

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [DATA_W-1:0] rdo_q, rdo_d;
   logic [BEAT_W-1:0] beat_s;
   logic              beat_last_s;

   beat_counter u_beat (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q == LOAD),
      .en    (state_q == DRAW),
      .beat  (beat_s),
      .last  (beat_last_s)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      rdo_d   = rdo_q;
      case (state_q)
         IDLE: begin
            row_d = {ROW_W{1'b0}};
            col_d = {COL_W{1'b0}};
            if (start) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            rdo_d   = row_data;
            state_d = LOAD;
         end
         LOAD: begin
            state_d = DRAW;
         end
         DRAW: begin
            if (beat_last_s) begin
               state_d = NEXT;
            end else begin
               state_d = DRAW;
            end
         end
         NEXT: begin
            if (col_q < COL_W'(GRID_COLS - 1)) begin
               col_d   = col_q + COL_W'(1);
               state_d = LOAD;
            end else if (row_q < ROW_W'(GRID_ROWS - 1)) begin
               col_d   = {COL_W{1'b0}};
               row_d   = row_q + ROW_W'(1);
               state_d = FETCH;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            row_d   = {ROW_W{1'b0}};
            col_d   = {COL_W{1'b0}};
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         row_q   <= {ROW_W{1'b0}};
         col_q   <= {COL_W{1'b0}};
         rdo_q   <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         rdo_q   <= rdo_d;
      end
   end

   // Strobes decode from flops only; beat 0 is the datapath's post-clear beat, so no plot.
   always_comb begin
      ld_x   = (state_q == LOAD);
      ld_y   = (state_q == LOAD);
      ld_c   = (state_q == LOAD);
      enable = (state_q == DRAW);
      plot   = (state_q == DRAW) && (beat_s != {BEAT_W{1'b0}});
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
   end

   assign row_addr     = row_q;
   assign col_addr     = col_q;
   assign row_data_out = rdo_q;

endmodule

// File: doc/cell_draw_control.md
Name: cell_draw_control

Overview:
- Initiator FSM that drives the cell-drawing datapath. It walks the 40x30 Game-of-Life board cell by cell and fetches each 40-bit row from the row store.
- For every cell it issues the ld_x/ld_y/ld_c load strobes, then enables the datapath's 4x4 pixel counter. It generates the VGA plot strobe for exactly the 16 valid pixels.
- Sits between the generation engine (start/done) and the datapath/VGA adapter. It redraws a full frame per start.

Parameters:
- GRID_COLS, 40, cells per row; col_addr range 0..GRID_COLS-1.
- GRID_ROWS, 30, rows per board; row_addr range 0..GRID_ROWS-1.
- DRAW_BEATS, 17, enable cycles per cell. This equals the datapath counter modulus: 16 pixels plus 1 wrap beat.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request a full-frame redraw; sampled in IDLE only.
- row_data  in  40  row store read data; valid 1 cycle after row_addr changes.
- row_addr  out  5  row store read address and datapath "register" input.
- col_addr  out  6  datapath "addr" input.
- ld_x  out  1  datapath x load strobe.
- ld_y  out  1  datapath y load strobe.
- ld_c  out  1  datapath colour load strobe.
- enable  out  1  datapath pixel-counter enable.
- plot  out  1  VGA write enable; high only while the datapath x/y/colour outputs are a valid pixel.
- busy  out  1  high from leaving IDLE until DONE completes.
- done  out  1  single-cycle pulse at end of frame.
- row_data_out  out  40  registered copy of row_data feeding the datapath "data" input.

Behaviour:
- Reset (async, any state) puts the FSM in IDLE. All outputs become 0, including row_addr, col_addr, the beat counter and row_data_out.
- States: IDLE, FETCH, LOAD, DRAW, NEXT, DONE.
- IDLE: waits for start=1, then goes to FETCH. row_addr=0, col_addr=0.
- FETCH: one cycle. row_addr is stable. At the end of FETCH, row_data is captured into row_data_out, then go to LOAD.
- LOAD: one cycle. ld_x=ld_y=ld_c=1, enable=0, plot=0. This clears the datapath counter (its counter reset is gated by ld_x/ld_y). Then go to DRAW with beat=0.
- DRAW: lasts exactly DRAW_BEATS cycles, beat 0..16, with enable=1 on every beat.
  - Datapath count equals beat, so plot = (beat != 0), giving 16 plot cycles, beats 1..16.
  - After beat 16 the datapath counter has wrapped to 0. Go to NEXT.
- NEXT: one cycle, no strobes.
  - If col_addr < GRID_COLS-1: col_addr+1, go to LOAD.
  - Else if row_addr < GRID_ROWS-1: col_addr=0, row_addr+1, go to FETCH.
  - Else go to DONE.
- DONE: one cycle. done=1. row_addr and col_addr return to 0, go to IDLE.
- busy = (state != IDLE).
- start while busy is ignored; it is not queued.
- Strobes never overlap: ld_* and enable are never high together.
- Timing:
  - Per cell: LOAD 1 + DRAW 17 + NEXT 1 = 19 cycles.
  - Per row: FETCH 1 + 40*19 = 761 cycles.
  - Frame: 30*761 + DONE 1 = 22831 cycles from the first FETCH cycle to the done pulse inclusive.
- Column 0 maps to row_data bit 39 inside the datapath; this block performs no bit selection.
- Widths: row_addr and col_addr compare and increment at their declared widths. Wrap beyond the GRID limits is unreachable.

Decomposition:
- Shared package cell_draw_pkg holds:
  - GRID_COLS, GRID_ROWS, DRAW_BEATS, CELL_PIX=4.
  - State enum {IDLE, FETCH, LOAD, DRAW, NEXT, DONE}.
- One natural sub-module, beat_counter: 5-bit counter with clear and enable, terminal flag at DRAW_BEATS-1.

Test Plan:
- Reset then start pulse:
  - FETCH at cycle 1, LOAD at cycle 2 with ld_x/ld_y/ld_c=1 and row_addr=0, col_addr=0.
  - plot high cycles 4..19 (16 cycles), enable high cycles 3..19.
- Full frame with row store returning 40'hAAAAAAAAAA:
  - exactly 30*40*16 = 19200 plot cycles.
  - done pulses once, 22831 cycles after the first FETCH.
  - busy falls the next cycle.
- Row boundary: at cell (row 0, col 39) NEXT gives row_addr=1, col_addr=0, then FETCH. row_data_out updates only after that FETCH.
- start asserted continuously during a frame: one frame only. A second frame starts only if start is high in IDLE after done.
- Async reset in the middle of DRAW (beat 8, row 5, col 12): all outputs 0 immediately with no clock edge. The next start restarts at row 0, col 0.
- Protocol check with the datapath model attached:
  - each plot cycle yields x=4*col+(k mod 4) and y=4*row+(k div 4) for k=0..15.
  - ld_* and enable are never high in the same cycle.
